// File: rtl/riscv_fetch_align.sv
// rtl/riscv_fetch_align.sv - RISC-V instruction fetch/align stage; RVC support enabled by RISCV_FETCH_RVC_EN
module riscv_fetch_align #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [31:0]     mem_rdata,
    input  logic            mem_err,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            out_compressed,
    output logic            out_fault
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_WAIT = 2'd1,
        F_DROP = 2'd2
    } fstate_t;

    fstate_t         state, state_nxt;
    logic [16:0]     buf_q [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [AW:0]     count, free_cnt, push_cnt, pop_cnt, need_cnt;
    logic [XLEN-1:0] fpc, dpc;
    logic            skip_low;
    logic            run;
    logic [16:0]     head_e, next_e;
    logic            is_rvc, illegal, push, pop;
    logic            unused_pc_bit;

    assign unused_pc_bit = redirect_pc[0];

    assign head_e = buf_q[rd_ptr];
    assign next_e = buf_q[rd_ptr + AW'(1)];

`ifdef RISCV_FETCH_RVC_EN
    assign is_rvc  = head_e[1:0] != 2'b11;
    assign illegal = 1'b0;
`else
    assign is_rvc  = 1'b0;
    assign illegal = head_e[1:0] != 2'b11;
`endif

    assign need_cnt  = is_rvc ? (AW+1)'(1) : (AW+1)'(2);
    assign free_cnt  = DEPTH_C - count;
    assign out_valid = count >= need_cnt;

    // run holds off requests until the first cycle after reset release
    assign mem_req  = run && (state == F_IDLE) && (free_cnt >= (AW+1)'(2)) && !redirect_valid;
    assign mem_addr = fpc;

    assign push     = (state == F_WAIT) && mem_rvalid && !redirect_valid;
    assign pop      = out_valid && out_ready && !redirect_valid;
    assign push_cnt = !push ? '0 : (skip_low ? (AW+1)'(1) : (AW+1)'(2));
    assign pop_cnt  = !pop ? '0 : need_cnt;

    assign out_instr      = !out_valid ? 32'h0 :
                            is_rvc ? {16'h0, head_e[15:0]} : {next_e[15:0], head_e[15:0]};
    assign out_pc         = dpc;
    assign out_compressed = out_valid && is_rvc;
    assign out_fault      = out_valid && (head_e[16] || (!is_rvc && next_e[16]) || illegal);

    // fetch FSM next state; a redirect overrides, dropping any response still owed
    always_comb begin
        state_nxt = state;
        case (state)
            F_IDLE:  if (mem_req && mem_gnt) state_nxt = F_WAIT;
            F_WAIT:  if (mem_rvalid) state_nxt = F_IDLE;
            F_DROP:  if (mem_rvalid) state_nxt = F_IDLE;
            default: state_nxt = F_IDLE;
        endcase
        if (redirect_valid) begin
            // a response landing in the redirect cycle retires the outstanding fetch
            if (mem_gnt || ((state != F_IDLE) && !mem_rvalid))
                state_nxt = F_DROP;
            else
                state_nxt = F_IDLE;
        end
    end

    // fetch FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= F_IDLE;
        else        state <= state_nxt;
    end

    // pointers, count, fetch/decode PCs and halfword-skip flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fpc      <= {RESET_PC[XLEN-1:2], 2'b00};
            dpc      <= RESET_PC;
            skip_low <= 1'b0;
            run      <= 1'b0;
        end else begin
            run <= 1'b1;
            if (redirect_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
                fpc    <= {redirect_pc[XLEN-1:2], 2'b00};
`ifdef RISCV_FETCH_RVC_EN
                dpc      <= {redirect_pc[XLEN-1:1], 1'b0};
                skip_low <= redirect_pc[1];
`else
                dpc      <= {redirect_pc[XLEN-1:2], 2'b00};
                skip_low <= 1'b0;
`endif
            end else begin
                if (mem_req && mem_gnt) fpc <= fpc + XLEN'(4);
                if (push) begin
                    wr_ptr   <= wr_ptr + push_cnt[AW-1:0];
                    skip_low <= 1'b0;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + pop_cnt[AW-1:0];
                    dpc    <= dpc + (is_rvc ? XLEN'(2) : XLEN'(4));
                end
                count <= count + push_cnt - pop_cnt;
            end
        end
    end

    // halfword buffer write: {err, data}, low halfword first unless skipped
    always_ff @(posedge clk) begin
        if (push) begin
            if (skip_low) begin
                buf_q[wr_ptr] <= {mem_err, mem_rdata[31:16]};
            end else begin
                buf_q[wr_ptr]          <= {mem_err, mem_rdata[15:0]};
                buf_q[wr_ptr + AW'(1)] <= {mem_err, mem_rdata[31:16]};
            end
        end
    end

endmodule
